// File: rtl/amplitude_scale_if.sv
`default_nettype none
// ============================================================================
//  Module      : amplitude_scale_if
//  Description : Sample-in / DAC-out bundle for the amplitude_scale stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface amplitude_scale_if #(
    parameter int DATA_W = 8
);
    logic [4:0]        amplitude;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              phase_wrap;
    logic [DATA_W-1:0] dac_data;
    logic              dac_valid;
    logic              ramp_busy;

    modport master (
        output amplitude, sample_in, sample_valid, phase_wrap,
        input  dac_data, dac_valid, ramp_busy
    );

    modport slave (
        input  amplitude, sample_in, sample_valid, phase_wrap,
        output dac_data, dac_valid, ramp_busy
    );
endinterface
`default_nettype wire

// File: rtl/amplitude_scale.sv
`default_nettype none
// ============================================================================
//  Module      : amplitude_scale
//  Description : Attenuates offset-binary samples by 1/2/4/8/16 around midscale;
//                the divisor only moves at waveform phase wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module amplitude_scale #(
    parameter int DATA_W  = 8,
    parameter bit RAMP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    amplitude_scale_if.slave  bus
);

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ATTEN = 2'd1,
        GAIN  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               target_q, target_d;
    logic [2:0]               cur_q, cur_d;
    logic signed [DATA_W-1:0] s1_q, s1_d;
    logic [2:0]               sh1_q;
    logic                     v1_q;
    logic signed [DATA_W-1:0] y_d;
    logic [DATA_W-1:0]        dac_q, dac_d;
    logic                     v2_q;
    logic                     busy_q;
    logic                     wrap_d;

    assign wrap_d = bus.sample_valid & bus.phase_wrap;

    // Unsupported divisor codes keep the previous target.
    always_comb begin
        target_d = target_q;
        case (bus.amplitude)
            5'd1:    target_d = 3'd0;
            5'd2:    target_d = 3'd1;
            5'd4:    target_d = 3'd2;
            5'd8:    target_d = 3'd3;
            5'd16:   target_d = 3'd4;
            default: target_d = target_q;
        endcase
    end

    // A wrap coincident with an amplitude change still sees the old target_q.
    always_comb begin
        cur_d   = cur_q;
        state_d = HOLD;
        if (wrap_d) begin
            if (RAMP_EN) begin
                case (state_q)
                    ATTEN:   cur_d = cur_q + 3'd1;
                    GAIN:    cur_d = cur_q - 3'd1;
                    default: cur_d = cur_q;
                endcase
            end else begin
                cur_d = target_q;
            end
        end
        if (cur_d < target_d)
            state_d = ATTEN;
        else if (cur_d > target_d)
            state_d = GAIN;
        else
            state_d = HOLD;
    end

    assign s1_d  = $signed(bus.sample_in - MID);
    assign y_d   = s1_q >>> sh1_q;
    assign dac_d = v1_q ? (y_d + MID) : dac_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HOLD;
            target_q <= 3'd0;
            cur_q    <= 3'd0;
            s1_q     <= '0;
            sh1_q    <= 3'd0;
            v1_q     <= 1'b0;
            dac_q    <= MID;
            v2_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            // The wrap sample itself already takes the updated shift.
            s1_q     <= s1_d;
            sh1_q    <= cur_d;
            v1_q     <= bus.sample_valid;
            dac_q    <= dac_d;
            v2_q     <= v1_q;
            busy_q   <= (state_d != HOLD);
        end
    end

    assign bus.dac_data  = dac_q;
    assign bus.dac_valid = v2_q;
    assign bus.ramp_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_amplitude_scale.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amplitude_scale
//  Description : Directed bench: jump-mode DUT (table) and ramp-mode DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_amplitude_scale;

    logic       clk;
    logic       rst_n;
    logic [4:0] amp;
    logic [7:0] smp;
    logic       vld;
    logic       wrp;
    int         n_cmp;
    int         n_err;

    amplitude_scale_if #(.DATA_W(8)) bus0 ();
    amplitude_scale_if #(.DATA_W(8)) bus1 ();

    assign bus0.amplitude    = amp;
    assign bus0.sample_in    = smp;
    assign bus0.sample_valid = vld;
    assign bus0.phase_wrap   = wrp;
    assign bus1.amplitude    = amp;
    assign bus1.sample_in    = smp;
    assign bus1.sample_valid = vld;
    assign bus1.phase_wrap   = wrp;

    amplitude_scale #(.DATA_W(8), .RAMP_EN(1'b0)) u_jump (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    amplitude_scale #(.DATA_W(8), .RAMP_EN(1'b1)) u_ramp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] amp;
        logic       v;
        logic       w;
        logic [7:0] s;
        logic [7:0] exp_dac;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a, input logic v, input logic w, input logic [7:0] s);
        amp = a;
        vld = v;
        wrp = w;
        smp = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Streams n zero samples with a wrap on the first; returns the wrap sample's output.
    task automatic run_period(input int n, output logic [7:0] wrap_out, output logic busy_out);
        wrap_out = 8'h00;
        busy_out = 1'b0;
        for (int k = 0; k < n; k++) begin
            drive(amp, 1'b1, (k == 0), 8'h00);
            tick();
            if (k == 1) begin
                wrap_out = bus1.dac_data;
                busy_out = bus1.ramp_busy;
            end
        end
    endtask

    logic [7:0] ramp_exp [4];
    logic [7:0] w_out;
    logic       b_out;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(5'd1, 1'b0, 1'b0, 8'h00);

        //            amp   v     w     s      dac    busy
        tbl[0]  = '{5'd1,  1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{5'd1,  1'b1, 1'b0, 8'h80, 8'h80, 1'b0};
        tbl[2]  = '{5'd1,  1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0};
        tbl[3]  = '{5'd1,  1'b0, 1'b0, 8'h55, 8'hFF, 1'b0};
        tbl[4]  = '{5'd16, 1'b1, 1'b0, 8'h10, 8'h10, 1'b1};
        tbl[5]  = '{5'd16, 1'b1, 1'b1, 8'h00, 8'h78, 1'b0};
        tbl[6]  = '{5'd16, 1'b1, 1'b0, 8'hFF, 8'h87, 1'b0};
        tbl[7]  = '{5'd16, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0};
        tbl[8]  = '{5'd16, 1'b1, 1'b0, 8'h40, 8'h7C, 1'b0};
        tbl[9]  = '{5'd16, 1'b1, 1'b0, 8'hC0, 8'h84, 1'b0};
        tbl[10] = '{5'd2,  1'b1, 1'b1, 8'h00, 8'h78, 1'b1};
        tbl[11] = '{5'd2,  1'b1, 1'b0, 8'h00, 8'h78, 1'b1};
        tbl[12] = '{5'd2,  1'b1, 1'b1, 8'h00, 8'h40, 1'b0};
        tbl[13] = '{5'd0,  1'b1, 1'b0, 8'hFF, 8'hBF, 1'b0};
        tbl[14] = '{5'd5,  1'b1, 1'b1, 8'hFF, 8'hBF, 1'b0};
        tbl[15] = '{5'd31, 1'b1, 1'b1, 8'h00, 8'h40, 1'b0};
        tbl[16] = '{5'd1,  1'b0, 1'b1, 8'h00, 8'h40, 1'b1};
        tbl[17] = '{5'd1,  1'b1, 1'b0, 8'h00, 8'h40, 1'b1};
        tbl[18] = '{5'd1,  1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[19] = '{5'd1,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

        ramp_exp[0] = 8'h40;
        ramp_exp[1] = 8'h60;
        ramp_exp[2] = 8'h70;
        ramp_exp[3] = 8'h78;

        #12;
        chk("reset_dac0",   bus0.dac_data,  8'h80);
        chk("reset_valid0", bus0.dac_valid, 0);
        chk("reset_busy0",  bus0.ramp_busy, 0);
        chk("reset_dac1",   bus1.dac_data,  8'h80);
        chk("reset_valid1", bus1.dac_valid, 0);
        chk("reset_busy1",  bus1.ramp_busy, 0);
        tick();
        rst_n = 1'b1;

        // Jump mode, back-to-back vectors: output of row i-1 is visible after row i.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].amp, tbl[i].v, tbl[i].w, tbl[i].s);
            tick();
            if (i > 0) begin
                chk($sformatf("tbl_dac[%0d]", i - 1),   bus0.dac_data,  tbl[i-1].exp_dac);
                chk($sformatf("tbl_valid[%0d]", i - 1), bus0.dac_valid, tbl[i-1].v);
            end
            chk($sformatf("tbl_busy[%0d]", i), bus0.ramp_busy, tbl[i].exp_busy);
        end
        drive(5'd1, 1'b0, 1'b0, 8'h00);
        tick();
        chk("tbl_dac[19]",   bus0.dac_data,  tbl[19].exp_dac);
        chk("tbl_valid[19]", bus0.dac_valid, tbl[19].v);

        // Ramp mode: 1 -> 16 steps one octave per 32-sample period.
        do_reset();
        drive(5'd16, 1'b0, 1'b0, 8'h00);
        tick();
        chk("ramp_busy_start", bus1.ramp_busy, 1);
        for (int p = 0; p < 4; p++) begin
            run_period(32, w_out, b_out);
            chk($sformatf("ramp_dac[%0d]", p),  w_out, ramp_exp[p]);
            chk($sformatf("ramp_busy[%0d]", p), b_out, (p != 3));
        end

        // Reversal from cur=2 back to full scale, no overshoot.
        do_reset();
        drive(5'd16, 1'b0, 1'b0, 8'h00);
        tick();
        run_period(4, w_out, b_out);
        run_period(4, w_out, b_out);
        chk("rev_cur2", w_out, 8'h60);
        drive(5'd1, 1'b0, 1'b0, 8'h00);
        tick();
        run_period(4, w_out, b_out);
        chk("rev_step1", w_out, 8'h40);
        chk("rev_busy1", b_out, 1);
        run_period(4, w_out, b_out);
        chk("rev_step0", w_out, 8'h00);
        chk("rev_busy0", b_out, 0);
        run_period(4, w_out, b_out);
        chk("rev_hold0", w_out, 8'h00);

        // Reset with samples in flight at cur=3.
        drive(5'd16, 1'b0, 1'b0, 8'h00);
        tick();
        for (int p = 0; p < 3; p++) run_period(4, w_out, b_out);
        chk("mid_cur3", w_out, 8'h70);
        drive(5'd16, 1'b1, 1'b0, 8'hFF);
        tick();
        drive(5'd16, 1'b1, 1'b0, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dac",   bus1.dac_data,  8'h80);
        chk("mid_rst_valid", bus1.dac_valid, 0);
        chk("mid_rst_busy",  bus1.ramp_busy, 0);
        chk("mid_rst_dac0",  bus0.dac_data,  8'h80);
        drive(5'd16, 1'b1, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid_c1", bus1.dac_valid, 0);
        tick();
        chk("post_rst_valid_c2", bus1.dac_valid, 1);
        chk("post_rst_dac",      bus1.dac_data,  8'h00);

        drive(5'd16, 1'b0, 1'b0, 8'h00);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
